// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Provides the instruction width, the NOP encoding, default reset PC and queue
// depth, and the entry type carried from fetch to the IF/ID register.
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned QDEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc_4;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_inst_queue.sv
// inst_queue: synchronous FIFO of fetch entries.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_push, i_entry  enqueue an entry
//   i_pop            dequeue the head
//   i_flush          empty the queue; wins over a same-cycle push
//   o_count          number of valid entries
//   o_head           head entry (registered storage, no write-through)
// The caller never pushes when full nor pops when empty.
module inst_queue
  import cpu_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  fetch_entry_t            i_entry,
  output logic [$clog2(QDEPTH):0] o_count,
  output fetch_entry_t            o_head
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned PW = $clog2(QDEPTH);

  fetch_entry_t  r_mem [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because QDEPTH is a power of two.
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && i_push) r_mem[r_wr_ptr] <= i_entry;
  end

  always_comb begin
    o_count = r_count;
    o_head  = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, issues in-order fetches over a req/gnt + rvalid handshake,
// buffers responses in inst_queue and presents {inst, pc+4} to IF/ID.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_redirect_valid, i_redirect_pc   load new PC and flush in-flight work
//   o_imem_req, o_imem_addr           fetch request and address
//   i_imem_gnt                        request accepted this cycle
//   i_imem_rvalid, i_imem_rdata       in-order response
//   o_out_valid, o_out_inst, o_out_pc_4, i_out_ready   IF/ID handshake
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_imem_req,
  output logic [31:0]       o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_out_valid,
  output logic [INST_W-1:0] o_out_inst,
  output logic [31:0]       o_out_pc_4,
  input  logic              i_out_ready
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QDEPTH_C = (CW + 1)'(QDEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_pop;
  logic          w_grant;
  logic          w_rsp;
  logic          w_push;
  logic [CW:0]   w_inflight;

  always_comb begin
    o_out_valid = (w_count != '0);
    w_pop       = o_out_valid & i_out_ready & ~i_redirect_valid;
    // outst + count never exceeds QDEPTH and pop implies count > 0, so no wrap.
    w_inflight  = {1'b0, r_outst} + {1'b0, w_count} - {{CW{1'b0}}, w_pop};
    o_imem_req  = ~i_rst & ~i_redirect_valid & (w_inflight < QDEPTH_C);
    o_imem_addr = r_pc;
    w_grant     = o_imem_req & i_imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    w_rsp       = i_imem_rvalid & (r_outst != '0);
    w_push      = w_rsp & (r_drop == '0) & ~i_redirect_valid;
    w_push_entry.inst = i_imem_rdata;
    w_push_entry.pc_4 = r_resp_pc + 32'd4;
    o_out_inst  = o_out_valid ? w_head.inst : NOP_INST;
    o_out_pc_4  = o_out_valid ? w_head.pc_4 : 32'h0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_outst   <= '0;
      r_drop    <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_grant) - CW'(w_rsp);
      if (i_redirect_valid) begin
        r_pc      <= i_redirect_pc;
        r_resp_pc <= i_redirect_pc;
        // Everything still in flight after this cycle belongs to the old path.
        r_drop    <= r_outst - CW'(w_rsp);
      end else begin
        if (w_grant) r_pc <= r_pc + 32'd4;
        if (w_push)  r_resp_pc <= r_resp_pc + 32'd4;
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      end
    end
  end

  inst_queue #(
    .QDEPTH (QDEPTH)
  ) u_inst_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_entry (w_push_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  a_no_orphan_rsp : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_imem_rvalid && (r_outst == '0)))
    else $error("imem_rvalid with no outstanding fetch");

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned QD = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, imem_gnt, imem_rvalid, out_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_inst, out_pc_4;

  if_fetch_unit #(
    .RESET_PC (RST_PC),
    .QDEPTH   (QD)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_gnt       (imem_gnt),
    .i_imem_rvalid    (imem_rvalid),
    .i_imem_rdata     (imem_rdata),
    .o_out_valid      (out_valid),
    .o_out_inst       (out_inst),
    .o_out_pc_4       (out_pc_4),
    .i_out_ready      (out_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;

  // Memory environment: fixed-latency, in-order responses.
  int          mem_due[$];
  logic [31:0] mem_addr[$];

  // Reference model: fetches in flight (with stale mark) and delivered queue.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } infl_t;
  infl_t        m_infl[$];
  fetch_entry_t m_outq[$];
  logic [31:0]  m_pc;

  // Observations of what the DUT handed to IF/ID and what it fetched.
  logic [31:0] seen_pc4[$];
  logic [31:0] seen_inst[$];
  int          seen_cyc[$];
  logic [31:0] gnt_addr[$];
  int          first_gnt_cyc = -1;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory, compare outputs to the model, advance both.
  // Entered and left at posedge+1 so callers may change inputs between calls.
  task automatic step();
    logic         e_valid, e_req, pop, dut_grant;
    fetch_entry_t e_head, e_new;
    infl_t        r;
    @(negedge clk);
    if (!rst && mem_due.size() > 0 && mem_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_at(mem_addr[0]);
      void'(mem_due.pop_front());
      void'(mem_addr.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    e_valid = (m_outq.size() > 0);
    e_head  = e_valid ? m_outq[0] : '0;
    pop     = e_valid & out_ready & ~redirect_valid;
    e_req   = !rst && !redirect_valid &&
              ((m_infl.size() + m_outq.size() - int'(pop)) < int'(QD));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_inst", out_inst, e_head.inst);
    chk("out_pc_4", out_pc_4, e_head.pc_4);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, m_pc);

    if (out_valid === 1'b1 && out_ready && !redirect_valid) begin
      seen_pc4.push_back(out_pc_4);
      seen_inst.push_back(out_inst);
      seen_cyc.push_back(cyc);
    end
    dut_grant = (imem_req === 1'b1) && imem_gnt && !rst;
    if (dut_grant) begin
      mem_due.push_back(cyc + lat);
      mem_addr.push_back(imem_addr);
      gnt_addr.push_back(imem_addr);
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
    end

    if (rst) begin
      mem_due.delete();
      mem_addr.delete();
      m_infl.delete();
      m_outq.delete();
      m_pc = RST_PC;
    end else begin
      if (pop) void'(m_outq.pop_front());
      if (imem_rvalid && m_infl.size() > 0) begin
        r = m_infl.pop_front();
        if (!r.stale && !redirect_valid) begin
          e_new.inst = inst_at(r.addr);
          e_new.pc_4 = r.addr + 32'd4;
          m_outq.push_back(e_new);
        end
      end
      if (redirect_valid) begin
        m_outq.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
        m_pc = redirect_pc;
      end else if (e_req && imem_gnt) begin
        r.addr  = m_pc;
        r.stale = 1'b0;
        m_infl.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_pop(input int n0, input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (seen_pc4.size() > n0) begin
        ok = 1;
        break;
      end
      step();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, n0, ok, bad;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1; m_pc = RST_PC;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) step();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_addr", imem_addr, RST_PC);

    // Reset release, L=1, streaming.
    rst = 1'b0;
    rel = cyc;
    repeat (8) step();
    chk("first_req_cycle", 32'(first_gnt_cyc), 32'(rel));
    chk("s1_pops", 32'(seen_pc4.size() >= 3), 32'd1);
    if (seen_pc4.size() >= 3) begin
      chk("first_valid_lat", 32'(seen_cyc[0] - first_gnt_cyc), 32'd2);
      chk("s1_pc4_0", seen_pc4[0], 32'd4);
      chk("s1_pc4_1", seen_pc4[1], 32'd8);
      chk("s1_pc4_2", seen_pc4[2], 32'd12);
      chk("s1_inst_0", seen_inst[0], 32'd0);
      chk("s1_inst_2", seen_inst[2], 32'd2);
      chk("s1_back_to_back", 32'(seen_cyc[2] - seen_cyc[0]), 32'd2);
    end

    // Stall for 6 cycles, then release.
    out_ready = 1'b0;
    repeat (6) step();
    chk("stall_req_low", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (6) step();
    bad = 0;
    for (int i = 1; i < seen_pc4.size(); i++) begin
      if (seen_pc4[i] != seen_pc4[i-1] + 32'd4) bad++;
      if (seen_inst[i] != seen_inst[i-1] + 32'd1) bad++;
    end
    chk("stream_no_gap_or_repeat", 32'(bad), 32'd0);

    // L=3, redirect with two fetches outstanding.
    lat = 3;
    repeat (4) step();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_infl.size() == 2) begin
        ok = 1;
        break;
      end
      step();
    end
    chk("s3_two_outstanding", 32'(ok), 32'd1);
    n0 = seen_pc4.size();
    do_redirect(32'h40);
    chk("s3_flush_valid", 32'(out_valid), 32'd0);
    wait_pop(n0, "s3_pop_timeout");
    if (seen_pc4.size() > n0) begin
      chk("s3_pc4", seen_pc4[n0], 32'h44);
      chk("s3_inst", seen_inst[n0], 32'h10);
    end

    // Redirect colliding with a response and a would-be pop.
    lat = 1;
    repeat (4) step();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_outq.size() > 0 && mem_due.size() > 0 && mem_due[0] <= cyc) begin
        ok = 1;
        break;
      end
      step();
    end
    chk("s4_collision_setup", 32'(ok), 32'd1);
    n0 = seen_pc4.size();
    do_redirect(32'h100);
    chk("s4_no_pop", 32'(seen_pc4.size()), 32'(n0));
    chk("s4_valid_low", 32'(out_valid), 32'd0);
    chk("s4_inst_nop", out_inst, 32'd0);
    wait_pop(n0, "s4_pop_timeout");
    if (seen_pc4.size() > n0) chk("s4_pc4", seen_pc4[n0], 32'h104);

    // Redirect to the top of the address space: PC wraps.
    gnt_addr.delete();
    n0 = seen_pc4.size();
    do_redirect(32'hFFFF_FFFC);
    wait_pop(n0, "s5_pop_timeout");
    if (seen_pc4.size() > n0) begin
      chk("s5_pc4_wrap", seen_pc4[n0], 32'h0);
      chk("s5_inst", seen_inst[n0], 32'h3FFF_FFFF);
    end
    chk("s5_grants", 32'(gnt_addr.size() >= 2), 32'd1);
    if (gnt_addr.size() >= 2) begin
      chk("s5_gnt0", gnt_addr[0], 32'hFFFF_FFFC);
      chk("s5_gnt1_wrap", gnt_addr[1], 32'h0);
    end

    // Reset mid-operation with queued and in-flight work.
    out_ready = 1'b0;
    lat = 3;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_outq.size() >= 1 && m_infl.size() >= 1) begin
        ok = 1;
        break;
      end
      step();
    end
    chk("s6_busy_setup", 32'(ok), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_addr", imem_addr, RST_PC);
    chk("s6_inst", out_inst, 32'd0);
    out_ready = 1'b1;
    lat = 1;
    seen_pc4.delete();
    seen_inst.delete();
    seen_cyc.delete();
    repeat (6) step();
    chk("s6_restart_pops", 32'(seen_pc4.size() >= 2), 32'd1);
    if (seen_pc4.size() >= 2) begin
      chk("s6_pc4_0", seen_pc4[0], 32'd4);
      chk("s6_inst_0", seen_inst[0], 32'd0);
      chk("s6_pc4_1", seen_pc4[1], 32'd8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the program counter, issues in-order requests to instruction memory over a grant/valid handshake, and buffers returned instructions in a small queue. It presents `{inst, pc+4}` to IF/ID under a valid/ready handshake, and discards in-flight fetches when a branch, jump or jr redirects the PC.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `QDEPTH`, 2, instruction queue depth (power of 2, ≥2); also the cap on outstanding plus buffered fetches.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `redirect_valid`  in  1  load `redirect_pc` and flush (branch/jump/jal/jr resolved downstream).
- `redirect_pc`  in  32  new fetch address, word aligned.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (current PC).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; responses return in order, latency ≥1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `out_valid`  out  1  queue head valid.
- `out_inst`  out  32  head instruction; 32'h0 (NOP) when `out_valid`=0.
- `out_pc_4`  out  32  head PC+4; 0 when `out_valid`=0.
- `out_ready`  in  1  IF/ID accepts (deasserted on decode stall).

## Operation
- State:
  - `pc`: next fetch address.
  - `resp_pc`: address of the next expected response.
  - `outst`: granted requests not yet returned.
  - `drop`: stale responses still to discard.
  - Instruction queue, entries `{inst, pc_4}`.
- Definition: `pop = out_valid & out_ready & ~redirect_valid`.
- `imem_req = ~rst & ~redirect_valid & (outst + count - pop < QDEPTH)`.
- `imem_addr = pc`.
- Grant (`imem_req & imem_gnt`): `pc <= pc+4`, `outst++`.
- Response (`imem_rvalid`): `outst--`.
  - If `drop>0` or `redirect_valid`: discard, and `drop--` if `drop>0`.
  - Otherwise push `{imem_rdata, resp_pc+4}` and set `resp_pc <= resp_pc+4`.
- Redirect:
  - `pc <= redirect_pc` and `resp_pc <= redirect_pc`.
  - Queue flushed (count <= 0).
  - `drop <= outst - imem_rvalid`, so every in-flight fetch is discarded.
  - No grant can occur in the redirect cycle.
- Push and pop in the same cycle are legal; count is unchanged.
- Arithmetic: PC+4 wraps modulo 2^32. `outst`, `drop` and `count` are `$clog2(QDEPTH)+1` bits and never exceed QDEPTH.
- Protocol violation: `imem_rvalid` while `outst==0`. The response is ignored; flag it with an assertion.
- Reset:
  - `pc = resp_pc = RESET_PC`; `outst = drop = count = 0`.
  - Outputs: `out_valid=0`, `out_inst=0`, `out_pc_4=0`, `imem_req=0`, `imem_addr=RESET_PC`.
  - Instruction memory shares `rst`, so no pre-reset response may arrive after reset.
  - Reset mid-operation discards the queue and all in-flight fetches.
  - `rst` has priority over `redirect_valid`.

## Timing
- First instruction:
  - First request in the cycle after `rst` deasserts.
  - With memory latency L, `out_valid` rises L+1 cycles after the grant cycle.
  - Queue output is registered; there is no rdata-to-out bypass.
- Throughput: sustained 1 instruction/cycle when QDEPTH ≥ L+1 and `out_ready`=1.
- Stall: with `out_ready`=0, `imem_req` drops once `outst+count` reaches QDEPTH. No instruction is lost or duplicated.
- Redirect:
  - Takes effect at the next edge.
  - First post-redirect request is issued the cycle after `redirect_valid`.
  - `out_valid`=0 from the cycle after redirect until the new response has been queued.
- Paths: `imem_req` has combinational paths from `redirect_valid`, `out_ready` and `rst`. The memory must not make `imem_gnt` combinationally depend on `imem_req` in a loop.

## Structure
- Shared package `cpu_pkg`:
  - `INST_W=32`.
  - `NOP_INST=32'h0`.
  - Default `RESET_PC`.
  - Typedef `fetch_entry_t {inst, pc_4}`.
- One sub-module: `inst_queue`.
  - Synchronous FIFO of `fetch_entry_t`, depth QDEPTH.
  - Signals: push, pop, flush, count, head.
  - Flush has priority over push.
- Top level holds `pc`, `resp_pc`, `outst`, `drop` and the request logic.

## Test plan
- Reset release, L=1, QDEPTH=2, `out_ready`=1, imem[k]=k → `out_valid` 2 cycles after the first grant. `out_pc_4` = 4, 8, 12… with `out_inst` = 0, 1, 2… on consecutive cycles.
- `out_ready`=0 for 6 cycles mid-stream → `imem_req` low after 2 fetches held. On release, sequence continues without gap or repeat.
- L=3 with `outst`=2 when `redirect_valid` and `redirect_pc`=0x40 → both stale responses dropped. Next `out_pc_4`=0x44, `out_inst`=imem[0x40].
- `redirect_valid`, `imem_rvalid` and `out_ready` all high in one cycle with a non-empty queue → no pop, response discarded. `count`=0 and `out_valid`=0 next cycle.
- Redirect to 0xFFFF_FFFC → `out_pc_4`=0x0000_0000 and next `imem_addr`=0x0000_0000.
- `rst` pulsed 1 cycle with queue full and `outst`>0 → next cycle `out_valid`=0 and `imem_addr`=RESET_PC. Fetch restarts from RESET_PC.
